// File: rtl/ref_mem_loader_if.sv
// Purpose: bundles the base stream, session control, memory write port and
//          status signals of the reference-memory loader.
// Signals:
//   start, base_addr             session control from host
//   s_valid, s_ready, s_base,    valid/ready base-code stream
//   s_last
//   we, addw, din                memory write port
//   busy, done, err, word_count  session status
// Modports: master = host/DMA side, slave = loader side.
interface ref_mem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BASE_WIDTH = 2
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  s_valid;
  logic                  s_ready;
  logic [BASE_WIDTH-1:0] s_base;
  logic                  s_last;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addw;
  logic [DATA_WIDTH-1:0] din;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH-1:0] word_count;

  modport master (
    output start, base_addr, s_valid, s_base, s_last,
    input  s_ready, we, addw, din, busy, done, err, word_count
  );

  modport slave (
    input  start, base_addr, s_valid, s_base, s_last,
    output s_ready, we, addw, din, busy, done, err, word_count
  );
endinterface

// File: rtl/ref_mem_loader.sv
// Purpose: write-side loader for the reference memory. Packs a stream of
//          2-bit base codes big-endian (first base in the MSBs) into memory
//          words and writes them to consecutive word-aligned byte addresses.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   io_bus  ref_mem_loader_if.slave (stream in, write port and status out)
// All outputs are registered.
module ref_mem_loader #(
  parameter int unsigned MEM_SIZE   = 4096,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BASE_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  ref_mem_loader_if.slave  io_bus
);

  localparam int unsigned BPW    = DATA_WIDTH / BASE_WIDTH;
  localparam int unsigned SLOT_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PACK, S_WRITE, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;

  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [SLOT_W-1:0]     r_slot;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_last_seen;
  logic                  r_s_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addw;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_word_count;

  logic                  w_hs;
  logic                  w_last_slot;
  logic                  w_addr_ok;
  int unsigned           w_shamt;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_s_ready_nxt;
  logic                  w_we_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;

  // s_ready is only ever high in PACK, so it doubles as the state qualifier.
  assign w_hs        = io_bus.s_valid & r_s_ready;
  assign w_last_slot = (r_slot == SLOT_W'(BPW - 1));
  assign w_addr_ok   = (r_cur_addr < ADDR_WIDTH'(MEM_SIZE));

  // Current word with the incoming base dropped into slot r_slot.
  assign w_shamt = (BPW - 1 - 32'(r_slot)) * BASE_WIDTH;
  assign w_word  = r_shift | (DATA_WIDTH'(io_bus.s_base) << w_shamt);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.start) w_next = S_PACK;
      S_PACK:  if (w_hs && (w_last_slot || io_bus.s_last)) w_next = S_WRITE;
      S_WRITE: w_next = (w_addr_ok && !r_last_seen) ? S_PACK : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    w_s_ready_nxt = 1'b0;
    w_we_nxt      = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    case (w_next)
      S_PACK:  begin w_s_ready_nxt = 1'b1; w_busy_nxt = 1'b1; end
      S_WRITE: begin w_we_nxt = w_addr_ok; w_busy_nxt = 1'b1; end
      S_DONE:  w_done_nxt = 1'b1;
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_addr   <= '0;
      r_slot       <= '0;
      r_shift      <= '0;
      r_last_seen  <= 1'b0;
      r_s_ready    <= 1'b0;
      r_we         <= 1'b0;
      r_addw       <= '0;
      r_din        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_s_ready <= w_s_ready_nxt;
      r_we      <= w_we_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      // addw/din only change alongside a write strobe.
      if (w_we_nxt) begin
        r_addw <= r_cur_addr;
        r_din  <= w_word;
      end
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_cur_addr   <= io_bus.base_addr & ~ADDR_WIDTH'(3);
            r_slot       <= '0;
            r_shift      <= '0;
            r_last_seen  <= 1'b0;
            r_word_count <= '0;
            r_err        <= 1'b0;
          end
        end
        S_PACK: begin
          if (w_hs) begin
            r_shift <= w_word;
            r_slot  <= r_slot + SLOT_W'(1);
            if (io_bus.s_last) r_last_seen <= 1'b1;
          end
        end
        S_WRITE: begin
          if (w_addr_ok) begin
            r_word_count <= r_word_count + ADDR_WIDTH'(1);
            r_cur_addr   <= r_cur_addr + ADDR_WIDTH'(4);
            r_slot       <= '0;
            r_shift      <= '0;
          end else begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.s_ready    = r_s_ready;
  assign io_bus.we         = r_we;
  assign io_bus.addw       = r_addw;
  assign io_bus.din        = r_din;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.err        = r_err;
  assign io_bus.word_count = r_word_count;

endmodule

// File: tb/tb_ref_mem_loader.sv
// Directed bench for ref_mem_loader: drives base-stream sessions through the
// interface and checks writes, status and handshake timing against
// hand-computed values.
module tb_ref_mem_loader;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   done_cnt;
  int   we_cnt;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  ref_mem_loader_if bus ();

  ref_mem_loader dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write / done monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.we) begin
      we_cnt++;
      wa.push_back(bus.addw);
      wd.push_back(bus.din);
    end
    if (bus.done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_session(input logic [31:0] addr);
    bus.start     = 1'b1;
    bus.base_addr = addr;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // Offer one base; optional random idle gaps with stray start pulses.
  task automatic send(input logic [1:0] b, input bit last, input int gap_pct);
    int n;
    n = 0;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct && n < 20) begin
      bus.s_valid   = 1'b0;
      bus.start     = 1'($urandom_range(0, 1));
      bus.base_addr = 32'h800;
      @(negedge clk);
      n++;
    end
    bus.start   = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_base  = b;
    bus.s_last  = last;
    n = 0;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("send_timeout", 64'(bus.s_ready), 64'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check(tag, 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int d0;
    int wsnap;
    errors = 0; checks = 0; done_cnt = 0; we_cnt = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0;
    bus.s_valid = 1'b0; bus.s_base = '0; bus.s_last = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_we", 64'(bus.we), 64'd0);
    check("rst_addw", 64'(bus.addw), 64'd0);
    check("rst_din", 64'(bus.din), 64'd0);
    check("rst_busy_done_err", 64'({bus.busy, bus.done, bus.err}), 64'd0);
    check("rst_word_count", 64'(bus.word_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 16 bases ACGT.. at 0x100
    wa.delete(); wd.delete(); d0 = done_cnt;
    start_session(32'h100);
    check("t1_busy", 64'(bus.busy), 64'd1);
    for (int i = 0; i < 16; i++) send(2'(i % 4), i == 15, 0);
    check("t1_we_latency", 64'(bus.we), 64'd1);
    check("t1_sready_low", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    check("t1_done_pulse", 64'(bus.done), 64'd1);
    wait_done("t1_done_once", d0);
    check("t1_nwrites", 64'(wa.size()), 64'd1);
    check("t1_addr", 64'(wa[0]), 64'h100);
    check("t1_data", 64'(wd[0]), 64'h1B1B1B1B);
    check("t1_word_count", 64'(bus.word_count), 64'd1);
    check("t1_err", 64'(bus.err), 64'd0);

    // 35 T bases at 0x0
    wa.delete(); wd.delete(); d0 = done_cnt;
    start_session(32'h0);
    for (int i = 0; i < 35; i++) begin
      send(2'b11, i == 34, 0);
      if (i == 15) begin
        check("t2_we_mid", 64'(bus.we), 64'd1);
        check("t2_sready_drop", 64'(bus.s_ready), 64'd0);
        @(negedge clk);
        check("t2_sready_back", 64'(bus.s_ready), 64'd1);
        check("t2_we_single", 64'(bus.we), 64'd0);
      end
    end
    wait_done("t2_done_once", d0);
    check("t2_nwrites", 64'(wa.size()), 64'd3);
    check("t2_a0", 64'(wa[0]), 64'h0);
    check("t2_d0", 64'(wd[0]), 64'hFFFFFFFF);
    check("t2_a1", 64'(wa[1]), 64'h4);
    check("t2_d1", 64'(wd[1]), 64'hFFFFFFFF);
    check("t2_a2", 64'(wa[2]), 64'h8);
    check("t2_d2", 64'(wd[2]), 64'hFC000000);
    check("t2_word_count", 64'(bus.word_count), 64'd3);

    // Single G with s_last at unaligned 0x7
    wa.delete(); wd.delete(); d0 = done_cnt;
    start_session(32'h7);
    send(2'b10, 1'b1, 0);
    check("t3_we", 64'(bus.we), 64'd1);
    check("t3_addw", 64'(bus.addw), 64'h4);
    check("t3_din", 64'(bus.din), 64'h80000000);
    @(negedge clk);
    check("t3_done_next", 64'(bus.done), 64'd1);
    wait_done("t3_done_once", d0);
    check("t3_nwrites", 64'(wa.size()), 64'd1);

    // Overflow at end of memory
    wa.delete(); wd.delete(); d0 = done_cnt;
    start_session(32'hFFC);
    for (int i = 0; i < 32; i++) send(2'b01, i == 31, 0);
    wait_done("t4_done_once", d0);
    check("t4_nwrites", 64'(wa.size()), 64'd1);
    check("t4_addr", 64'(wa[0]), 64'hFFC);
    check("t4_data", 64'(wd[0]), 64'h55555555);
    check("t4_err", 64'(bus.err), 64'd1);
    check("t4_word_count", 64'(bus.word_count), 64'd1);
    repeat (3) @(negedge clk);
    check("t4_err_held", 64'(bus.err), 64'd1);
    check("t4_idle_busy", 64'(bus.busy), 64'd0);

    // Reset mid-word, then a clean session
    wa.delete(); wd.delete();
    start_session(32'h200);
    check("t5_err_cleared", 64'(bus.err), 64'd0);
    for (int i = 0; i < 8; i++) send(2'b11, 1'b0, 0);
    wsnap = we_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_busy", 64'(bus.busy), 64'd0);
    check("t5_rst_sready", 64'(bus.s_ready), 64'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_no_we_after_rst", 64'(we_cnt), 64'(wsnap));
    d0 = done_cnt;
    start_session(32'h40);
    for (int i = 0; i < 16; i++) send(2'(3 - (i % 4)), i == 15, 0);
    wait_done("t5_done_once", d0);
    check("t5_nwrites", 64'(wa.size()), 64'd1);
    check("t5_addr", 64'(wa[0]), 64'h40);
    check("t5_data", 64'(wd[0]), 64'hE4E4E4E4);

    // 35 T bases with random gaps and stray start pulses
    wa.delete(); wd.delete(); d0 = done_cnt;
    start_session(32'h0);
    for (int i = 0; i < 35; i++) send(2'b11, i == 34, 50);
    bus.start = 1'b0;
    wait_done("t6_done_once", d0);
    check("t6_nwrites", 64'(wa.size()), 64'd3);
    check("t6_a0", 64'(wa[0]), 64'h0);
    check("t6_d0", 64'(wd[0]), 64'hFFFFFFFF);
    check("t6_a1", 64'(wa[1]), 64'h4);
    check("t6_d1", 64'(wd[1]), 64'hFFFFFFFF);
    check("t6_a2", 64'(wa[2]), 64'h8);
    check("t6_d2", 64'(wd[2]), 64'hFC000000);
    check("t6_word_count", 64'(bus.word_count), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
